// File: rtl/noc_request_axilite_pkg.sv
// noc_request_axilite_pkg: Piton NoC field layout, NC request constants and request FSM states
// Holds the header field positions and widths shared by the request and response bridges,
// the NC load/store message types, the data-size encodings and two small helper functions.
package noc_request_axilite_pkg;
   localparam int NOC_DATA_WIDTH = 64;
   localparam int NOC_CHIPID_WIDTH = 14;
   localparam int NOC_X_WIDTH = 8;
   localparam int NOC_Y_WIDTH = 8;
   localparam int MSG_LENGTH_WIDTH = 8;
   localparam int MSG_TYPE_WIDTH = 8;
   localparam int MSG_MSHRID_WIDTH = 8;
   localparam int MSG_ADDR_WIDTH = 48;
   localparam int MSG_DATA_SIZE_WIDTH = 3;
   // chipid/x/y sit at the same positions in HDR0 (destination) and HDR2 (source)
   localparam int MSG_CHIPID_LO = 50;
   localparam int MSG_X_LO = 42;
   localparam int MSG_Y_LO = 34;
   localparam int MSG_LENGTH_LO = 22;
   localparam int MSG_TYPE_LO = 14;
   localparam int MSG_MSHRID_LO = 6;
   localparam int MSG_ADDR_LO = 16;
   localparam int MSG_DATA_SIZE_LO = 13;
   localparam logic [MSG_TYPE_WIDTH-1:0] MSG_TYPE_NC_LOAD_REQ = 8'd14;
   localparam logic [MSG_TYPE_WIDTH-1:0] MSG_TYPE_NC_STORE_REQ = 8'd15;
   localparam logic [MSG_DATA_SIZE_WIDTH-1:0] MSG_DATA_SIZE_4B = 3'd3;
   localparam logic [MSG_DATA_SIZE_WIDTH-1:0] MSG_DATA_SIZE_8B = 3'd4;
   localparam logic [MSG_DATA_SIZE_WIDTH-1:0] MSG_DATA_SIZE_16B = 3'd5;
   localparam logic [MSG_DATA_SIZE_WIDTH-1:0] MSG_DATA_SIZE_32B = 3'd6;
   localparam logic [MSG_DATA_SIZE_WIDTH-1:0] MSG_DATA_SIZE_64B = 3'd7;

   typedef enum logic [2:0] {IDLE, HDR0, HDR1, HDR2, DATA} req_state_e;
   typedef enum logic {RR_READ, RR_WRITE} rr_e;

   function automatic logic [MSG_DATA_SIZE_WIDTH-1:0] data_size_enc(input int bytes);
      return bytes == 4 ? MSG_DATA_SIZE_4B :
             bytes == 8 ? MSG_DATA_SIZE_8B :
             bytes == 16 ? MSG_DATA_SIZE_16B :
             bytes == 32 ? MSG_DATA_SIZE_32B : MSG_DATA_SIZE_64B;
   endfunction

   // byte-reverse every 64-bit word of a flit
   function automatic logic [NOC_DATA_WIDTH-1:0] swap64(input logic [NOC_DATA_WIDTH-1:0] d);
      logic [NOC_DATA_WIDTH-1:0] r;
      r = '0;
      for (int w = 0; w < NOC_DATA_WIDTH / 64; w++)
         for (int b = 0; b < 8; b++)
            r[w*64 + b*8 +: 8] = d[w*64 + (7-b)*8 +: 8];
      return r;
   endfunction
endpackage

// File: rtl/axilite_req_buf.sv
// axilite_req_buf: single-entry valid/ready holding register
// Ports: clk, rst_n; in_data/in_valid/in_ready upstream handshake (in_ready = !full);
//        clr empties the entry; full/data expose the held beat.
module axilite_req_buf #(
   parameter int DW = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] in_data,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          clr,
   output logic          full,
   output logic [DW-1:0] data
);
   assign in_ready = !full;

   // clr only happens while full, so in_ready is low then and a refill waits one cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full <= 1'b0;
         data <= '0;
      end else if (clr) begin
         full <= 1'b0;
      end else if (in_valid && in_ready) begin
         full <= 1'b1;
         data <= in_data;
      end
   end
endmodule

// File: rtl/noc_request_axilite.sv
// noc_request_axilite: AXI-Lite AR/AW/W requests to Piton NC load/store request packets
// Ports: clk, rst_n (async, active-low);
//        m_axi_ar*/aw*/w* AXI-Lite request channels (wstrb accepted and ignored);
//        src_*/dst_* quasi-static NoC coordinates placed in HDR2/HDR0;
//        noc_valid_out/noc_data_out/noc_ready_in outgoing flit stream.
module noc_request_axilite
   import noc_request_axilite_pkg::*;
#(
   parameter int AXI_LITE_DATA_WIDTH = 512,
   parameter int AXI_LITE_ADDR_WIDTH = 64,
   parameter bit SWAP_ENDIANESS = 1'b0
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [AXI_LITE_ADDR_WIDTH-1:0]   m_axi_araddr,
   input  logic                             m_axi_arvalid,
   output logic                             m_axi_arready,
   input  logic [AXI_LITE_ADDR_WIDTH-1:0]   m_axi_awaddr,
   input  logic                             m_axi_awvalid,
   output logic                             m_axi_awready,
   input  logic [AXI_LITE_DATA_WIDTH-1:0]   m_axi_wdata,
   input  logic [AXI_LITE_DATA_WIDTH/8-1:0] m_axi_wstrb,
   input  logic                             m_axi_wvalid,
   output logic                             m_axi_wready,
   input  logic [NOC_CHIPID_WIDTH-1:0]      src_chipid,
   input  logic [NOC_X_WIDTH-1:0]           src_xpos,
   input  logic [NOC_Y_WIDTH-1:0]           src_ypos,
   input  logic [NOC_CHIPID_WIDTH-1:0]      dst_chipid,
   input  logic [NOC_X_WIDTH-1:0]           dst_xpos,
   input  logic [NOC_Y_WIDTH-1:0]           dst_ypos,
   output logic                             noc_valid_out,
   output logic [NOC_DATA_WIDTH-1:0]        noc_data_out,
   input  logic                             noc_ready_in
);
   localparam int N = AXI_LITE_DATA_WIDTH / NOC_DATA_WIDTH;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
   localparam logic [MSG_LENGTH_WIDTH-1:0] LD_LEN = MSG_LENGTH_WIDTH'(2);
   localparam logic [MSG_LENGTH_WIDTH-1:0] ST_LEN = MSG_LENGTH_WIDTH'(2 + N);
   localparam logic [MSG_DATA_SIZE_WIDTH-1:0] DSIZE = data_size_enc(AXI_LITE_DATA_WIDTH / 8);

   req_state_e state, next_state;
   rr_e rr_last;
   logic is_wr, grant_wr, rd_pend, wr_pend, fire, last;
   logic ar_full, aw_full, w_full;
   logic [AXI_LITE_ADDR_WIDTH-1:0] ar_addr, aw_addr;
   logic [AXI_LITE_DATA_WIDTH-1:0] w_data;
   logic [CW-1:0] cnt;
   logic [MSG_MSHRID_WIDTH-1:0] mshr_ctr;
   logic [NOC_DATA_WIDTH-1:0] hdr0, hdr1, hdr2, raw, dflit;
   logic unused_wstrb;

   assign unused_wstrb = ^m_axi_wstrb;

   axilite_req_buf #(.DW(AXI_LITE_ADDR_WIDTH)) u_ar (
      .clk(clk), .rst_n(rst_n), .in_data(m_axi_araddr), .in_valid(m_axi_arvalid),
      .in_ready(m_axi_arready), .clr(fire && last && !is_wr), .full(ar_full), .data(ar_addr)
   );
   axilite_req_buf #(.DW(AXI_LITE_ADDR_WIDTH)) u_aw (
      .clk(clk), .rst_n(rst_n), .in_data(m_axi_awaddr), .in_valid(m_axi_awvalid),
      .in_ready(m_axi_awready), .clr(fire && last && is_wr), .full(aw_full), .data(aw_addr)
   );
   axilite_req_buf #(.DW(AXI_LITE_DATA_WIDTH)) u_w (
      .clk(clk), .rst_n(rst_n), .in_data(m_axi_wdata), .in_valid(m_axi_wvalid),
      .in_ready(m_axi_wready), .clr(fire && last && is_wr), .full(w_full), .data(w_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         is_wr <= 1'b0;
         rr_last <= RR_WRITE;
         cnt <= '0;
         mshr_ctr <= '0;
      end else begin
         state <= next_state;
         // every grant records its type, so contended reads and writes alternate
         if (state == IDLE && (rd_pend || wr_pend)) begin
            is_wr <= grant_wr;
            rr_last <= grant_wr ? RR_WRITE : RR_READ;
         end
         if (fire && state == DATA)
            cnt <= last ? '0 : cnt + 1'b1;
         if (fire && state == HDR0)
            mshr_ctr <= mshr_ctr + 1'b1;
      end
   end

   always_comb begin
      rd_pend = ar_full;
      wr_pend = aw_full && w_full;
      grant_wr = wr_pend && (!rd_pend || rr_last == RR_READ);
      noc_valid_out = state != IDLE;
      fire = noc_valid_out && noc_ready_in;
      last = is_wr ? (state == DATA && cnt == LAST_CNT) : state == HDR2;
      next_state = state;
      case (state)
         IDLE:    next_state = (rd_pend || wr_pend) ? HDR0 : IDLE;
         HDR0:    next_state = fire ? HDR1 : HDR0;
         HDR1:    next_state = fire ? HDR2 : HDR1;
         HDR2:    next_state = fire ? (is_wr ? DATA : IDLE) : HDR2;
         DATA:    next_state = (fire && last) ? IDLE : DATA;
         default: next_state = IDLE;
      endcase
   end

   // every flit source is registered or quasi-static, so the output holds during stalls
   always_comb begin
      hdr0 = '0;
      hdr0[MSG_CHIPID_LO +: NOC_CHIPID_WIDTH] = dst_chipid;
      hdr0[MSG_X_LO +: NOC_X_WIDTH] = dst_xpos;
      hdr0[MSG_Y_LO +: NOC_Y_WIDTH] = dst_ypos;
      hdr0[MSG_LENGTH_LO +: MSG_LENGTH_WIDTH] = is_wr ? ST_LEN : LD_LEN;
      hdr0[MSG_TYPE_LO +: MSG_TYPE_WIDTH] = is_wr ? MSG_TYPE_NC_STORE_REQ : MSG_TYPE_NC_LOAD_REQ;
      hdr0[MSG_MSHRID_LO +: MSG_MSHRID_WIDTH] = mshr_ctr;
      hdr1 = '0;
      hdr1[MSG_ADDR_LO +: MSG_ADDR_WIDTH] = MSG_ADDR_WIDTH'(is_wr ? aw_addr : ar_addr);
      hdr1[MSG_DATA_SIZE_LO +: MSG_DATA_SIZE_WIDTH] = DSIZE;
      hdr2 = '0;
      hdr2[MSG_CHIPID_LO +: NOC_CHIPID_WIDTH] = src_chipid;
      hdr2[MSG_X_LO +: NOC_X_WIDTH] = src_xpos;
      hdr2[MSG_Y_LO +: NOC_Y_WIDTH] = src_ypos;
      raw = w_data[cnt * NOC_DATA_WIDTH +: NOC_DATA_WIDTH];
      dflit = SWAP_ENDIANESS ? swap64(raw) : raw;
      noc_data_out = state == HDR0 ? hdr0 :
                     state == HDR1 ? hdr1 :
                     state == HDR2 ? hdr2 :
                     state == DATA ? dflit : '0;
   end
endmodule
